// File: rtl/fifo_status_pkg.sv
// -----------------------------------------------------------------------------
// fifo_status_pkg
//   Shared types and reset constants for fifo_status_detector.
//   - level_state_e : occupancy level FSM state (2-bit encoding)
//   - RST_*         : reset values of the registered status flags
// -----------------------------------------------------------------------------
package fifo_status_pkg;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } level_state_e;

  localparam logic RST_ALMOST_EMPTY = 1'b1;
  localparam logic RST_ALMOST_FULL  = 1'b0;
  localparam logic RST_BECAME       = 1'b0;
  localparam logic RST_ERR          = 1'b0;

endpackage : fifo_status_pkg

// File: rtl/fifo_status_detector_cell_popcount.sv
// -----------------------------------------------------------------------------
// cell_popcount
//   Purely combinational count of set bits in a N_CELLS-wide vector.
//   Ports:
//     bits   in   N_CELLS  vector to count
//     count  out  CNT_W    number of ones in bits
//   The result cannot wrap because N_CELLS < 2**CNT_W.
// -----------------------------------------------------------------------------
module cell_popcount #(
  parameter int N_CELLS = 16,
  parameter int CNT_W   = $clog2(N_CELLS + 1)
) (
  input  logic [N_CELLS-1:0] bits,
  output logic [CNT_W-1:0]   count
);

  // Written as a linear sum for readability; synthesis rebalances it into an
  // adder tree since the operands are independent.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    count = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

endmodule : cell_popcount

// File: rtl/fifo_status_detector.sv
// -----------------------------------------------------------------------------
// fifo_status_detector
//   Registered occupancy status for an N_CELLS-deep cell FIFO, derived from the
//   per-cell empty bits, plus sticky overflow/underflow flags from put/get.
//   Two-stage pipeline: stage 1 samples e_i, stage 2 registers the count and
//   every flag derived from it. Latency e_i -> outputs is 2 cycles.
//
//   Ports:
//     clk           in   1        rising-edge clock
//     reset         in   1        synchronous, active-high reset
//     e_i           in   N_CELLS  per-cell empty bit (1 = cell empty)
//     put_i         in   1        producer write strobe
//     get_i         in   1        consumer read strobe
//     err_clr_i     in   1        clears sticky error flags
//     count_o       out  CNT_W    occupied cell count
//     empty / full  out  1        level FSM in S_EMPTY / S_FULL
//     almost_empty  out  1        low-watermark flag
//     almost_full   out  1        high-watermark flag
//     became_empty  out  1        1-cycle pulse on entry to S_EMPTY
//     became_full   out  1        1-cycle pulse on entry to S_FULL
//     ovf_o / udf_o out  1        sticky overflow / underflow
//
//   Configuration macro: FIFO_STATUS_HYST_EN
//     defined   : watermark flags use HYST cells of hysteresis
//     undefined : watermark flags are plain registered compares (HYST unused)
// -----------------------------------------------------------------------------
module fifo_status_detector
  import fifo_status_pkg::*;
#(
  parameter int N_CELLS  = 16,
  parameter int AE_LEVEL = 2,
  parameter int AF_LEVEL = 14,
  parameter int HYST     = 1,
  parameter int CNT_W    = $clog2(N_CELLS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_CELLS-1:0] e_i,
  input  logic               put_i,
  input  logic               get_i,
  input  logic               err_clr_i,
  output logic [CNT_W-1:0]   count_o,
  output logic               empty,
  output logic               full,
  output logic               almost_empty,
  output logic               almost_full,
  output logic               became_empty,
  output logic               became_full,
  output logic               ovf_o,
  output logic               udf_o
);

  // Elaboration-time guard against inconsistent parameter sets.
  if (N_CELLS < 2 || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > N_CELLS ||
      HYST < 0 || HYST > AF_LEVEL - AE_LEVEL || CNT_W != $clog2(N_CELLS + 1)) begin : g_param_check
    $error("fifo_status_detector: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] OCC_FULL = CNT_W'(N_CELLS);
  localparam logic [CNT_W-1:0] AE_Q     = CNT_W'(AE_LEVEL);
  localparam logic [CNT_W-1:0] AF_Q     = CNT_W'(AF_LEVEL);
`ifdef FIFO_STATUS_HYST_EN
  localparam logic [CNT_W-1:0] AF_CLR_Q = CNT_W'(AF_LEVEL - HYST);
  localparam logic [CNT_W-1:0] AE_CLR_Q = CNT_W'(AE_LEVEL + HYST);
`endif

  logic [N_CELLS-1:0] e_q;
  logic [CNT_W-1:0]   occ;
  level_state_e       state_q, state_d;
  logic               ae_d, af_d;
  logic               ovf_set, udf_set;

  // Stage 2 counts occupied cells, i.e. the zeros of the sampled empty vector.
  cell_popcount #(
    .N_CELLS (N_CELLS),
    .CNT_W   (CNT_W)
  ) u_popcount (
    .bits  (~e_q),
    .count (occ)
  );

  // Next level state depends only on the new occupancy.
  always_comb begin
    state_d = S_PARTIAL;
    if (occ == '0)            state_d = S_EMPTY;
    else if (occ == OCC_FULL) state_d = S_FULL;
  end

  always_comb begin
`ifdef FIFO_STATUS_HYST_EN
    // Between the set and clear thresholds each flag holds its last value.
    af_d = almost_full;
    if (occ >= AF_Q)          af_d = 1'b1;
    else if (occ < AF_CLR_Q)  af_d = 1'b0;
    ae_d = almost_empty;
    if (occ <= AE_Q)          ae_d = 1'b1;
    else if (occ > AE_CLR_Q)  ae_d = 1'b0;
`else
    af_d = (occ >= AF_Q);
    ae_d = (occ <= AE_Q);
`endif
  end

  // Simultaneous put and get is a legal pass-through, never an error.
  assign ovf_set = put_i && !get_i && full;
  assign udf_set = get_i && !put_i && empty;

  assign empty = (state_q == S_EMPTY);
  assign full  = (state_q == S_FULL);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (reset) begin
      e_q          <= '1;
      count_o      <= '0;
      state_q      <= S_EMPTY;
      almost_empty <= RST_ALMOST_EMPTY;
      almost_full  <= RST_ALMOST_FULL;
      became_empty <= RST_BECAME;
      became_full  <= RST_BECAME;
      ovf_o        <= RST_ERR;
      udf_o        <= RST_ERR;
    end else begin
      e_q          <= e_i;
      count_o      <= occ;
      state_q      <= state_d;
      almost_empty <= ae_d;
      almost_full  <= af_d;
      became_empty <= (state_d == S_EMPTY) && (state_q != S_EMPTY);
      became_full  <= (state_d == S_FULL)  && (state_q != S_FULL);
      // A new error event wins over a clear in the same cycle.
      ovf_o        <= ovf_set || (ovf_o && !err_clr_i);
      udf_o        <= udf_set || (udf_o && !err_clr_i);
    end
  end

endmodule : fifo_status_detector

// File: tb/tb_fifo_status_detector.sv
// -----------------------------------------------------------------------------
// tb_fifo_status_detector
//   Directed self-checking bench for fifo_status_detector (default parameters).
//   Inputs change 1 time unit after a rising edge; outputs are sampled at the
//   same point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_fifo_status_detector;

  localparam int N_CELLS = 16;
  localparam int CNT_W   = 5;

  logic               clk = 1'b0;
  logic               reset;
  logic [N_CELLS-1:0] e_i;
  logic               put_i, get_i, err_clr_i;
  logic [CNT_W-1:0]   count_o;
  logic               empty, full, almost_empty, almost_full;
  logic               became_empty, became_full, ovf_o, udf_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fifo_status_detector #(
    .N_CELLS  (N_CELLS),
    .AE_LEVEL (2),
    .AF_LEVEL (14),
    .HYST     (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .e_i          (e_i),
    .put_i        (put_i),
    .get_i        (get_i),
    .err_clr_i    (err_clr_i),
    .count_o      (count_o),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .became_empty (became_empty),
    .became_full  (became_full),
    .ovf_o        (ovf_o),
    .udf_o        (udf_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Applies an occupancy of k cells (lowest k cells full) and waits out the
  // 2-cycle pipeline.
  task automatic set_occ(input int k);
    logic [N_CELLS-1:0] all_empty;
    all_empty = '1;
    e_i = all_empty << k;
    step(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, 32'(count_o), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_ae"}, 32'(almost_empty), 32'd1);
    check({tag, "_af"}, 32'(almost_full), 32'd0);
    check({tag, "_bempty"}, 32'(became_empty), 32'd0);
    check({tag, "_bfull"}, 32'(became_full), 32'd0);
    check({tag, "_ovf"}, 32'(ovf_o), 32'd0);
    check({tag, "_udf"}, 32'(udf_o), 32'd0);
  endtask

  logic exp_ae, exp_af;

  // Expected watermark flags for occupancy k, given the previous expectation.
  task automatic model_almost(input int k);
`ifdef FIFO_STATUS_HYST_EN
    if (k >= 14)     exp_af = 1'b1;
    else if (k < 13) exp_af = 1'b0;
    if (k <= 2)      exp_ae = 1'b1;
    else if (k > 3)  exp_ae = 1'b0;
`else
    exp_af = (k >= 14);
    exp_ae = (k <= 2);
`endif
  endtask

  initial begin
    reset     = 1'b1;
    e_i       = '1;
    put_i     = 1'b0;
    get_i     = 1'b0;
    err_clr_i = 1'b0;

    // 1. Reset state and quiet release.
    step(2);
    check_reset_outputs("rst");
    reset = 1'b0;
    step(1);
    check("rel_bempty", 32'(became_empty), 32'd0);
    check("rel_empty", 32'(empty), 32'd1);
    step(1);
    check("rel2_bempty", 32'(became_empty), 32'd0);

    // 2. All empty to all full in one cycle; 2-cycle latency, 1-cycle pulse.
    e_i = '0;
    step(1);
    check("lat1_full", 32'(full), 32'd0);
    check("lat1_count", 32'(count_o), 32'd0);
    step(1);
    check("full_count", 32'(count_o), 32'd16);
    check("full_full", 32'(full), 32'd1);
    check("full_empty", 32'(empty), 32'd0);
    check("full_af", 32'(almost_full), 32'd1);
    check("full_ae", 32'(almost_empty), 32'd0);
    check("full_bfull", 32'(became_full), 32'd1);
    step(1);
    check("full_bfull_drop", 32'(became_full), 32'd0);
    check("full_hold", 32'(full), 32'd1);

    // Full back to empty in one cycle.
    set_occ(0);
    check("fe_empty", 32'(empty), 32'd1);
    check("fe_bempty", 32'(became_empty), 32'd1);
    step(1);
    check("fe_bempty_drop", 32'(became_empty), 32'd0);

    // 3. Occupancy ramp 0..16..0, one cell per step.
    exp_ae = 1'b1;
    exp_af = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      set_occ(k);
      model_almost(k);
      check($sformatf("up%0d_count", k), 32'(count_o), 32'(k));
      check($sformatf("up%0d_ae", k), 32'(almost_empty), 32'(exp_ae));
      check($sformatf("up%0d_af", k), 32'(almost_full), 32'(exp_af));
    end
    for (int k = 15; k >= 0; k--) begin
      set_occ(k);
      model_almost(k);
      check($sformatf("dn%0d_count", k), 32'(count_o), 32'(k));
      check($sformatf("dn%0d_ae", k), 32'(almost_empty), 32'(exp_ae));
      check($sformatf("dn%0d_af", k), 32'(almost_full), 32'(exp_af));
      check($sformatf("dn%0d_full", k), 32'(full), 32'd0);
    end

    // 4. Overflow: set, hold, clear, set-wins-over-clear, legal put+get.
    set_occ(16);
    put_i = 1'b1;
    step(1);
    put_i = 1'b0;
    check("ovf_set", 32'(ovf_o), 32'd1);
    step(1);
    check("ovf_hold", 32'(ovf_o), 32'd1);
    err_clr_i = 1'b1;
    step(1);
    err_clr_i = 1'b0;
    check("ovf_clr", 32'(ovf_o), 32'd0);
    err_clr_i = 1'b1;
    put_i     = 1'b1;
    step(1);
    err_clr_i = 1'b0;
    put_i     = 1'b0;
    check("ovf_set_wins", 32'(ovf_o), 32'd1);
    err_clr_i = 1'b1;
    step(1);
    err_clr_i = 1'b0;
    check("ovf_clr2", 32'(ovf_o), 32'd0);
    put_i = 1'b1;
    get_i = 1'b1;
    step(1);
    put_i = 1'b0;
    get_i = 1'b0;
    check("ovf_putget", 32'(ovf_o), 32'd0);
    check("udf_full_get", 32'(udf_o), 32'd0);

    // 5. Underflow, and legal put+get while empty.
    set_occ(0);
    get_i = 1'b1;
    step(1);
    get_i = 1'b0;
    check("udf_set", 32'(udf_o), 32'd1);
    err_clr_i = 1'b1;
    step(1);
    err_clr_i = 1'b0;
    check("udf_clr", 32'(udf_o), 32'd0);
    put_i = 1'b1;
    get_i = 1'b1;
    step(1);
    put_i = 1'b0;
    get_i = 1'b0;
    check("udf_putget", 32'(udf_o), 32'd0);
    put_i = 1'b1;
    step(1);
    put_i = 1'b0;
    check("ovf_empty_put", 32'(ovf_o), 32'd0);

    // 6. Reset mid-operation at occupancy 9 with both error flags set.
    set_occ(16);
    put_i = 1'b1;
    step(1);
    put_i = 1'b0;
    set_occ(0);
    get_i = 1'b1;
    step(1);
    get_i = 1'b0;
    set_occ(9);
    check("pre_count", 32'(count_o), 32'd9);
    check("pre_ovf", 32'(ovf_o), 32'd1);
    check("pre_udf", 32'(udf_o), 32'd1);
    reset = 1'b1;
    e_i   = '0;
    put_i = 1'b1;
    get_i = 1'b1;
    step(1);
    check_reset_outputs("midrst");
    reset = 1'b0;
    put_i = 1'b0;
    get_i = 1'b0;
    e_i   = '1;
    step(2);
    check("post_bempty", 32'(became_empty), 32'd0);
    check("post_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fifo_status_detector
